// File: rtl/pulse_capture_if.sv
// Capture-side bundle for pulse_capture: control inputs and measurement results.
// The slave view belongs to the capture block, the master view to its host.
interface pulse_capture_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             pulse_in;
    logic [WIDTH-1:0] timeout_cnt;
    logic [WIDTH-1:0] freq_cnt;
    logic [WIDTH-1:0] duty_cnt;
    logic             valid;
    logic             timeout;
    logic             level;

    modport master (
        output en,
        output pulse_in,
        output timeout_cnt,
        input  freq_cnt,
        input  duty_cnt,
        input  valid,
        input  timeout,
        input  level
    );

    modport slave (
        input  en,
        input  pulse_in,
        input  timeout_cnt,
        output freq_cnt,
        output duty_cnt,
        output valid,
        output timeout,
        output level
    );
endinterface

// File: rtl/pulse_capture.sv
// Pulse-train capture: measures rise-to-rise period and high time in clk cycles,
// with a live-compared timeout and saturating counters.
module pulse_capture #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            rst,
    pulse_capture_if.slave bus
);
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

    state_t             state;
    logic [STAGES-1:0]  sync_q;
    logic               prev;
    logic               level;
    logic               rise;
    logic               tmo;
    logic [WIDTH-1:0]   p;
    logic [WIDTH-1:0]   h;
    logic [WIDTH-1:0]   p_inc;
    logic [WIDTH-1:0]   h_inc;
    logic [WIDTH-1:0]   freq_q;
    logic [WIDTH-1:0]   duty_q;
    logic               valid_q;
    logic               timeout_q;

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev;
    assign tmo   = (bus.timeout_cnt != '0) && (p == bus.timeout_cnt);
    assign p_inc = (p == MAX) ? p : p + ONE;
    assign h_inc = (h == MAX) ? h : h + ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], bus.pulse_in};
            prev   <= level;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            p         <= '0;
            h         <= '0;
            freq_q    <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!bus.en) begin
                // Disabling discards any partial period; results hold.
                state     <= IDLE;
                p         <= '0;
                h         <= '0;
                timeout_q <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: state <= ARM;
                    ARM: begin
                        if (rise) begin
                            p     <= ONE;
                            h     <= ONE;
                            state <= MEAS;
                        end else if (tmo) begin
                            timeout_q <= 1'b1;
                            freq_q    <= '0;
                            duty_q    <= '0;
                            p         <= '0;
                        end else begin
                            p <= p_inc;
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            freq_q    <= p;
                            duty_q    <= h;
                            valid_q   <= 1'b1;
                            timeout_q <= 1'b0;
                            p         <= ONE;
                            h         <= ONE;
                        end else if (tmo) begin
                            timeout_q <= 1'b1;
                            freq_q    <= '0;
                            duty_q    <= '0;
                            p         <= '0;
                            h         <= '0;
                            state     <= ARM;
                        end else begin
                            p <= p_inc;
                            if (level) h <= h_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.freq_cnt = freq_q;
    assign bus.duty_cnt = duty_q;
    assign bus.valid    = valid_q;
    assign bus.timeout  = timeout_q;
    assign bus.level    = level;
endmodule

// File: tb/tb_pulse_capture.sv
// Randomized bench for pulse_capture: stimulus is a list of pulse periods, the
// scoreboard holds the results and timeouts those periods must produce.
module tb_pulse_capture;
    localparam int W   = 8;
    localparam int S   = 3;
    localparam int MAX = (1 << W) - 1;

    typedef struct {
        bit is_to;
        int t;
        int f;
        int d;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   edges = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 0;
    bit   tprev = 0;
    ev_t  q[$];

    int   t_cur = 0;
    bit   flag = 0;
    bit   cnt = 0;
    int   cn = 0;
    int   cd = 0;
    int   held_f = 0;
    int   held_d = 0;

    pulse_capture_if #(.WIDTH(W)) bus ();

    pulse_capture #(
        .WIDTH(W),
        .SYNC_STAGES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    function automatic int sat(input int x);
        return (x > MAX) ? MAX : x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edges);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // A rise at drive edge e closes the previous period and opens a new one.
    task automatic start_period(input int e, input int n, input int d);
        ev_t ev;
        if (cnt && (t_cur == 0 || cn <= t_cur)) begin
            ev.is_to = 1'b0;
            ev.t = e + 1 + S;
            ev.f = sat(cn);
            ev.d = sat(cd);
            q.push_back(ev);
            flag = 0;
        end
        cnt = (bus.en === 1'b1);
        cn  = n;
        cd  = d;
        if (cnt && t_cur != 0 && n > t_cur && !flag) begin
            ev.is_to = 1'b1;
            ev.t = e + 1 + S + t_cur;
            ev.f = 0;
            ev.d = 0;
            q.push_back(ev);
            flag = 1;
        end
    endtask

    task automatic period(input int n, input int d,
                          input int drop = -1, input int rst_at = -1);
        cyc();
        bus.pulse_in = 1'b1;
        start_period(edges, n, d);
        for (int j = 1; j < n; j++) begin
            cyc();
            if (j == d - 1 && d >= S + 2)
                chk("level_high", int'(bus.level), 1);
            if (j == n - 1 && n - d >= S + 2)
                chk("level_low", int'(bus.level), 0);
            if (j == rst_at + 1 && rst_at >= 0) begin
                rst = 1'b0;
                chk("rst_freq", int'(bus.freq_cnt), 0);
                chk("rst_duty", int'(bus.duty_cnt), 0);
                chk("rst_valid", int'(bus.valid), 0);
                chk("rst_timeout", int'(bus.timeout), 0);
                chk("rst_level", int'(bus.level), 0);
                held_f = 0;
                held_d = 0;
                cnt = 0;
                flag = 0;
            end
            if (j == rst_at) rst = 1'b1;
            bus.pulse_in = (j < d);
            bus.en = (j != drop);
            if (j == drop) begin
                cnt = 0;
                flag = 0;
            end
        end
    endtask

    task automatic begin_phase(input int t);
        cyc();
        bus.en = 1'b0;
        bus.pulse_in = 1'b0;
        cnt = 0;
        flag = 0;
        cyc();
        bus.timeout_cnt = W'(t);
        t_cur = t;
        cyc();
        bus.en = 1'b1;
    endtask

    task automatic end_phase();
        period(S + 4, 1);
    endtask

    task automatic rand_periods(input int num, input int nmax);
        int n;
        int d;
        for (int i = 0; i < num; i++) begin
            n = $urandom_range(nmax, 2);
            d = $urandom_range(n - 1, 1);
            period(n, d);
        end
    endtask

    always @(negedge clk) begin : monitor
        bit  v;
        bit  tr;
        ev_t e;
        if (mon_on) begin
            v  = (bus.valid === 1'b1);
            tr = (bus.timeout === 1'b1) && !tprev;
            tprev = (bus.timeout === 1'b1);
            if (v || tr) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: valid=%0b timeout_rise=%0b at edge %0d, none expected",
                             v, tr, edges);
                end else begin
                    e = q.pop_front();
                    chk(e.is_to ? "timeout_event" : "valid_event",
                        int'({v, tr}), e.is_to ? 1 : 2);
                    chk("event_edge", edges, e.t);
                    if (v) chk("timeout_cleared", int'(bus.timeout), 0);
                    held_f = e.f;
                    held_d = e.d;
                end
            end else if (q.size() > 0 && q[0].t < edges) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event: expected %s at edge %0d, got no event",
                         e.is_to ? "timeout" : "valid", e.t);
            end
            chk("freq_cnt", int'(bus.freq_cnt), held_f);
            chk("duty_cnt", int'(bus.duty_cnt), held_d);
        end
    end

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.pulse_in = 1'b0;
        bus.timeout_cnt = '0;
        repeat (3) cyc();
        chk("reset_freq", int'(bus.freq_cnt), 0);
        chk("reset_duty", int'(bus.duty_cnt), 0);
        chk("reset_valid", int'(bus.valid), 0);
        chk("reset_timeout", int'(bus.timeout), 0);
        chk("reset_level", int'(bus.level), 0);
        rst = 1'b0;
        mon_on = 1;

        begin_phase(0);
        repeat (6) period(10, 3);
        repeat (6) period(7, 6);
        period(20, 5, 10);
        repeat (2) period(20, 5);
        period(20, 5, -1, 8);
        repeat (2) period(20, 5);
        repeat (2) period(300, 280);
        period(270, 100);
        period(12, 4);
        rand_periods(25, 40);
        end_phase();

        begin_phase(20);
        repeat (3) period(10, 3);
        period(60, 57);
        repeat (4) period(10, 3);
        end_phase();

        begin_phase(10);
        repeat (3) period(10, 4);
        period(11, 4);
        repeat (3) period(10, 4);
        end_phase();

        begin_phase($urandom_range(16, 8));
        rand_periods(40, 24);
        end_phase();

        for (int i = 0; i < 200 && q.size() != 0; i++) cyc();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d events still pending, expected 0", q.size());
        end
        repeat (5) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pulse_capture.md
# pulse_capture

Measures an external pulse train and reports its period and high time in clock cycles. It is the receive-side counterpart of `gen_pulse`: driving `pulse_in` from a `gen_pulse` output configured with `freq_cnt = N` and `duty_cnt = D` yields `freq_cnt = N` and `duty_cnt = D`. The block sits in the peripheral/utils layer and is intended for a PWM-capture / input-timer peripheral that exposes the results to software.

## Interface

Parameters:
- `WIDTH`, default 32: width of the counters and result registers.
- `SYNC_STAGES`, default 2, minimum 2: flip-flop stages in the `pulse_in` synchronizer.

Ports:
- `clk`  input  1  single clock; all logic on its rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `en`  input  1  capture enable.
- `pulse_in`  input  1  asynchronous pulse input.
- `timeout_cnt`  input  WIDTH  cycle limit without a rising edge; 0 disables timeout. Compared live every cycle.
- `freq_cnt`  output  WIDTH  last measured period in clk cycles (rise to rise).
- `duty_cnt`  output  WIDTH  high cycles within that period.
- `valid`  output  1  one-cycle strobe when `freq_cnt`/`duty_cnt` are updated by a measurement.
- `timeout`  output  1  sticky flag: no rising edge within `timeout_cnt` cycles.
- `level`  output  1  synchronized level of `pulse_in` (last synchronizer stage).

## Operation

Input conditioning:
- `pulse_in` passes through a `SYNC_STAGES` synchronizer; the last stage is `level`.
- `prev` is `level` delayed by one cycle.
- `rise = level & ~prev`.
- The synchronizer and `prev` run whenever `rst` is low, independent of `en`.

Internal counters:
- `p`: period/wait counter, WIDTH bits.
- `h`: high-time counter, WIDTH bits.
- Both saturate at 2^WIDTH−1 and never wrap.

States:
- **IDLE**
  - Entered on reset or whenever `en = 0`, from any state.
  - `p = h = 0`, `valid = 0`, `timeout` cleared.
  - `freq_cnt` and `duty_cnt` hold their values.
  - `rise` is ignored.
  - Goes to ARM when `en = 1`.
- **ARM** (waiting for the first rising edge)
  - On `rise`: `p <= 1`, `h <= 1`, go to MEAS. No result is produced.
  - Otherwise, if `timeout_cnt != 0` and `p == timeout_cnt`:
    - `timeout <= 1`, `freq_cnt <= 0`, `duty_cnt <= 0`, `p <= 0`; stay in ARM.
  - Otherwise `p <= p + 1`.
- **MEAS**
  - On `rise`:
    - `freq_cnt <= p`, `duty_cnt <= h`, `valid <= 1`, `timeout <= 0`.
    - `p <= 1`, `h <= 1`; stay in MEAS.
  - Otherwise, if `timeout_cnt != 0` and `p == timeout_cnt`:
    - `timeout <= 1`, `freq_cnt <= 0`, `duty_cnt <= 0`, `p <= 0`, `h <= 0`; go to ARM.
  - Otherwise:
    - `p <= p + 1`.
    - `h <= h + 1` if `level = 1`.

Boundary rules:
- `rise` and the timeout condition in the same cycle: `rise` wins.
  - Periods N ≤ `timeout_cnt` are measured.
  - A period of N = `timeout_cnt + 1` times out.
- Input already high when `en` rises: no edge is seen; capture waits for the next low→high transition.
- Constant input (duty 0 or duty ≥ period on the generator side): no rises, so timeout fires. Software distinguishes stuck-high from stuck-low with `level`.
- `en` dropped mid-measurement: the partial measurement is discarded and no `valid` is produced.
- Results are always a coherent pair from the same period.

## Timing

Reset values (the cycle after `rst` is sampled high):
- `freq_cnt = 0`, `duty_cnt = 0`, `valid = 0`, `timeout = 0`, `level = 0`.
- State IDLE; synchronizer stages and `prev` are 0.

Latency:
- Let clock edge k be the first edge that samples `pulse_in` high.
- `rise` is asserted in the cycle after edge k + SYNC_STAGES − 1.
- `valid`, `freq_cnt` and `duty_cnt` update at edge k + SYNC_STAGES.
- All outputs are registered.

Handshake:
- `valid` is high for exactly one cycle per measurement; there is no back-pressure.
- `freq_cnt`/`duty_cnt` are stable until the next `valid`, timeout, or reset.

Measurement window and throughput:
- The first `valid` follows the second detected rising edge after entering ARM.
- Sustained output is one result per input period.

## Test plan

- **Loopback with `gen_pulse`:** `freq_cnt = 10`, `duty_cnt = 3`, `en = 1`, `timeout_cnt = 0`. Required: the first `valid` after two rises, then `valid` every 10 cycles, each with `freq_cnt = 10`, `duty_cnt = 3`, and `timeout = 0`.
- **Period change:** switch the generator from 10/3 to 7/7−1 (7/6). Required: at most one transitional result, then steady `freq_cnt = 7`, `duty_cnt = 6`.
- **Stuck input:** hold `pulse_in = 1` with `timeout_cnt = 20` after a valid measurement. Required: `timeout = 1` and `freq_cnt = duty_cnt = 0` exactly 20 cycles after the last counted cycle; `level = 1`. Next, resume the 10/3 train. Required: `timeout` clears on the first `valid` after re-arming.
- **Timeout boundary:** `timeout_cnt = 10`. A period of 10 gives `valid` with `freq_cnt = 10`. A period of 11 gives `timeout` with no `valid`.
- **Enable/reset mid-measurement:** drop `en` for 1 cycle mid-period. Required: no `valid`, `timeout = 0`, outputs hold, and the next result comes two rises later. Separately, assert `rst` mid-period. Required: all outputs are 0 the next cycle.
- **Saturation:** `WIDTH = 4`, `timeout_cnt = 0`, period 20, high 18. Required: `freq_cnt = 15`, `duty_cnt = 15`, no wrap.
